// File: rtl/jb_aes_key_expand_pkg.sv
// Shared AES types, round constants and S-box for the key schedule
// and the SubBytes stage.
package jb_aes_key_expand_pkg;

   typedef logic [0:3][0:3][7:0] block128_t;
   typedef logic [31:0]          word32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXPAND,
      S_READY
   } ks_state_t;

   localparam int NUM_RK = 11;

   localparam logic [7:0] RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Byte x of the S-box lives at bits [(255-x)*8 +: 8]
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      int i;
      i = 255 - int'(x);
      return SBOX_TBL[i*8 +: 8];
   endfunction

endpackage

// File: rtl/jb_aes_subword.sv
// Combinational SubWord: four parallel S-box lookups.
module jb_aes_subword
   import jb_aes_key_expand_pkg::*;
(
   input  word32 i_word,
   output word32 o_word
);

   assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                    sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/jb_aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, all eleven
// held in registers with a flat bus and an indexed read port.
module jb_aes_key_expand
   import jb_aes_key_expand_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int KEY_WIDTH  = 128
) (
   input  logic                               clk,
   input  logic                               nRst,
   input  logic                               i_key_valid,
   output logic                               o_key_ready,
   input  logic [KEY_WIDTH-1:0]               i_key,
   output logic                               o_busy,
   output logic                               o_keys_valid,
   input  logic [3:0]                         i_rk_index,
   output logic [KEY_WIDTH-1:0]               o_rk_out,
   output logic [(NUM_ROUNDS+1)*KEY_WIDTH-1:0] o_rk_all
);

   generate
      if (NUM_ROUNDS != 10 || KEY_WIDTH != 128) begin : g_bad_cfg
         $fatal(1, "jb_aes_key_expand supports AES-128 only");
      end
   endgenerate

   ks_state_t r_state;
   ks_state_t w_state_nx;
   logic [3:0] r_cnt;
   logic       r_keys_valid;
   block128_t  r_rk [NUM_RK];

   logic       w_accept;
   logic [3:0] w_idx;
   block128_t  w_prev;
   block128_t  w_next;
   word32      w_rot;
   word32      w_sub;
   word32      w_temp;
   logic [7:0] w_rcon;

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      unique case (r_state)
         S_IDLE, S_READY: begin
            if (i_key_valid) begin
               w_accept   = 1'b1;
               w_state_nx = S_EXPAND;
            end
         end
         S_EXPAND: begin
            if (r_cnt == 4'd10) w_state_nx = S_READY;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign o_key_ready  = (r_state != S_EXPAND);
   assign o_busy       = (r_state == S_EXPAND);
   assign o_keys_valid = r_keys_valid;

   // Previous round key feeds the next one
   assign w_idx = r_cnt - 4'd1;

   always_comb begin
      w_prev = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (w_idx == 4'(i)) w_prev = r_rk[i];
      end
   end

   assign w_rcon = (w_idx < 4'd10) ? RCON[w_idx] : 8'h00;
   assign w_rot  = {w_prev[3][1], w_prev[3][2], w_prev[3][3], w_prev[3][0]};

   jb_aes_subword u_subword (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   assign w_temp = w_sub ^ {w_rcon, 24'h0};

   always_comb begin
      w_next    = '0;
      w_next[0] = w_prev[0] ^ w_temp;
      w_next[1] = w_prev[1] ^ w_next[0];
      w_next[2] = w_prev[2] ^ w_next[1];
      w_next[3] = w_prev[3] ^ w_next[2];
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_keys_valid <= 1'b0;
         for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_keys_valid <= (w_state_nx == S_READY);
         if (w_accept) begin
            r_rk[0] <= i_key;
            r_cnt   <= 4'd1;
         end else if (r_state == S_EXPAND) begin
            r_rk[r_cnt] <= w_next;
            if (r_cnt != 4'd10) r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   always_comb begin
      o_rk_out = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (i_rk_index == 4'(i)) o_rk_out = r_rk[i];
      end
   end

   always_comb begin
      o_rk_all = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         o_rk_all[i*128 +: 128] = r_rk[i];
      end
   end

endmodule

// File: tb/tb_jb_aes_key_expand.sv
// Directed bench for jb_aes_key_expand using FIPS-197 and all-zero keys.
module tb_jb_aes_key_expand;

   logic          clk;
   logic          nRst;
   logic          key_valid;
   logic          key_ready;
   logic [127:0]  key;
   logic          busy;
   logic          keys_valid;
   logic [3:0]    rk_index;
   logic [127:0]  rk_out;
   logic [1407:0] rk_all;

   int n_checks;
   int n_fails;

   logic [127:0] fips_rk [11];
   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   jb_aes_key_expand dut (
      .clk          (clk),
      .nRst         (nRst),
      .i_key_valid  (key_valid),
      .o_key_ready  (key_ready),
      .i_key        (key),
      .o_busy       (busy),
      .o_keys_valid (keys_valid),
      .i_rk_index   (rk_index),
      .o_rk_out     (rk_out),
      .o_rk_all     (rk_all)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!keys_valid && n < 30) begin
         tick();
         n++;
      end
      n_checks++;
      if (!keys_valid) begin
         n_fails++;
         $display("FAIL %s: keys_valid timeout got %0b want 1", name, keys_valid);
      end
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      key_valid = 1'b0;
      key = '0;
      rk_index = 4'd0;
      #12;
      n_checks++;
      if (busy !== 1'b0 || keys_valid !== 1'b0 || key_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL reset_ctl: got busy=%b kv=%b kr=%b want 0 0 1", busy, keys_valid, key_ready);
      end
      n_checks++;
      if (rk_all !== '0 || rk_out !== '0) begin
         n_fails++;
         $display("FAIL reset_keys: got rk_out=%h want 0", rk_out);
      end
      nRst = 1'b1;
      tick();
   endtask

   task automatic test_fips();
      int n;
      n_checks++;
      if (key_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL fips_ready: got %b want 1", key_ready);
      end
      key = FIPS_KEY;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 30) begin
         tick();
         n++;
      end
      n_checks++;
      if (n != 10) begin
         n_fails++;
         $display("FAIL fips_busy_cycles: got %0d want 10", n);
      end
      n_checks++;
      if (keys_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL fips_keys_valid: got %b want 1", keys_valid);
      end
      for (int r = 0; r < 11; r++) begin
         n_checks++;
         if (rk_all[r*128 +: 128] !== fips_rk[r]) begin
            n_fails++;
            $display("FAIL fips_rk%0d: got %h want %h", r, rk_all[r*128 +: 128], fips_rk[r]);
         end
      end
   endtask

   task automatic test_zero_key();
      key = '0;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n_checks++;
      if (keys_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL zero_kv_drop: got %b want 0", keys_valid);
      end
      wait_valid("zero_wait");
      rk_index = 4'd1;
      #1;
      n_checks++;
      if (rk_out !== ZERO_RK1) begin
         n_fails++;
         $display("FAIL zero_rk1: got %h want %h", rk_out, ZERO_RK1);
      end
      rk_index = 4'd10;
      #1;
      n_checks++;
      if (rk_out !== ZERO_RK10) begin
         n_fails++;
         $display("FAIL zero_rk10: got %h want %h", rk_out, ZERO_RK10);
      end
      rk_index = 4'd0;
      #1;
      n_checks++;
      if (rk_out !== 128'h0) begin
         n_fails++;
         $display("FAIL zero_rk0: got %h want 0", rk_out);
      end
   endtask

   task automatic test_ignore_during_expand();
      key = FIPS_KEY;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick();
      tick();
      tick();
      key = '0;
      key_valid = 1'b1;
      n_checks++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
         n_fails++;
         $display("FAIL ignore_ready: got kr=%b busy=%b want 0 1", key_ready, busy);
      end
      tick();
      key_valid = 1'b0;
      wait_valid("ignore_wait");
      n_checks++;
      if (rk_all[10*128 +: 128] !== fips_rk[10]) begin
         n_fails++;
         $display("FAIL ignore_rk10: got %h want %h", rk_all[10*128 +: 128], fips_rk[10]);
      end
      n_checks++;
      if (rk_all[127:0] !== FIPS_KEY) begin
         n_fails++;
         $display("FAIL ignore_rk0: got %h want %h", rk_all[127:0], FIPS_KEY);
      end
   endtask

   task automatic test_back_to_back();
      // READY holding FIPS keys; zero key offered and held high
      key = '0;
      key_valid = 1'b1;
      tick();
      n_checks++;
      if (keys_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL b2b_kv_drop: got %b want 0", keys_valid);
      end
      for (int i = 0; i < 10; i++) tick();
      n_checks++;
      if (keys_valid !== 1'b1 || rk_all[10*128 +: 128] !== ZERO_RK10) begin
         n_fails++;
         $display("FAIL b2b_rk10: got kv=%b rk10=%h want 1 %h", keys_valid, rk_all[10*128 +: 128], ZERO_RK10);
      end
      key = FIPS_KEY;
      tick();
      key_valid = 1'b0;
      n_checks++;
      if (keys_valid !== 1'b0 || busy !== 1'b1) begin
         n_fails++;
         $display("FAIL b2b_restart: got kv=%b busy=%b want 0 1", keys_valid, busy);
      end
      wait_valid("b2b_wait");
      n_checks++;
      if (rk_all[10*128 +: 128] !== fips_rk[10]) begin
         n_fails++;
         $display("FAIL b2b_rk10_fips: got %h want %h", rk_all[10*128 +: 128], fips_rk[10]);
      end
   endtask

   task automatic test_reset_mid_expand();
      key = FIPS_KEY;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #2;
      nRst = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || keys_valid !== 1'b0 || key_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL midrst_ctl: got busy=%b kv=%b kr=%b want 0 0 1", busy, keys_valid, key_ready);
      end
      n_checks++;
      if (rk_all !== '0) begin
         n_fails++;
         $display("FAIL midrst_rk_all: got rk0=%h rk10=%h want 0", rk_all[127:0], rk_all[1407:1280]);
      end
      tick();
      nRst = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || keys_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL midrst_idle: got busy=%b kv=%b want 0 0", busy, keys_valid);
      end
   endtask

   task automatic test_index_sweep();
      logic [127:0] exp_v;
      key = FIPS_KEY;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      wait_valid("sweep_wait");
      for (int i = 0; i < 16; i++) begin
         rk_index = 4'(i);
         #1;
         exp_v = (i <= 10) ? fips_rk[i] : 128'h0;
         n_checks++;
         if (rk_out !== exp_v) begin
            n_fails++;
            $display("FAIL sweep_idx%0d: got %h want %h", i, rk_out, exp_v);
         end
         if (i <= 10) begin
            n_checks++;
            if (rk_out !== rk_all[i*128 +: 128]) begin
               n_fails++;
               $display("FAIL sweep_slice%0d: got %h want %h", i, rk_out, rk_all[i*128 +: 128]);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      fips_rk[0]  = FIPS_KEY;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      test_reset();
      test_fips();
      test_zero_key();
      test_ignore_during_expand();
      test_back_to_back();
      test_reset_mid_expand();
      test_index_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
